// File: rtl/audio_capture_controller_pkg.sv
// Shared definitions for the audio capture controller: register map, status layout,
// sample word packing and the DMA FSM state encoding.
package audio_capture_controller_pkg;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_BUF_A_ADDR = 4'd1;
  localparam logic [3:0] REG_BUF_A_SIZE = 4'd2;
  localparam logic [3:0] REG_BUF_B_ADDR = 4'd3;
  localparam logic [3:0] REG_BUF_B_SIZE = 4'd4;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_CLR_OVERRUN = 1;

  localparam int STAT_A_ARMED = 0;
  localparam int STAT_B_ARMED = 1;
  localparam int STAT_CUR_BUF = 2;
  localparam int STAT_OVERRUN = 3;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } sample_word_t;

  typedef enum logic {
    DMA_IDLE = 1'b0,
    DMA_REQ  = 1'b1
  } dma_state_t;

  function automatic logic [31:0] word_address(input logic [31:0] base, input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/audio_capture_fifo.sv
// Synchronous FIFO between sample capture and DMA. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module audio_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_capture_controller.sv
// Stereo sample capture into CPU-armed ping-pong memory buffers via a DMA write port.
// state    | meaning:  DMA_IDLE waiting for a queued word and an armed buffer; DMA_REQ word presented, waiting for ready
module audio_capture_controller
  import audio_capture_controller_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [3:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_dma_request,
  output logic [31:0] o_dma_address,
  output logic [31:0] o_dma_wdata,
  input  logic        i_dma_ready,
  input  logic        i_input_sample_clock,
  input  logic [15:0] i_input_sample_left,
  input  logic [15:0] i_input_sample_right,
  output logic        o_buffer_done
);

  dma_state_t   state;
  logic         enable, overrun, cur_buf, a_armed, b_armed, stream_live;
  logic [31:0]  a_addr, a_size, b_addr, b_size, index;
  logic         sclk_meta, sclk_sync, sclk_prev;
  logic         sample_edge, capture_ok;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  sample_word_t in_word;
  logic [31:0]  head_word;
  logic         cur_armed;
  logic [31:0]  cur_base, cur_size;
  logic         last_word;
  logic [31:0]  read_data;

  // stream_live keeps capture running across a buffer switch even if the next buffer is not armed yet
  assign sample_edge   = sclk_sync & ~sclk_prev;
  assign capture_ok    = sample_edge & enable & (a_armed | b_armed | stream_live);
  assign fifo_pop      = (state == DMA_REQ) & i_dma_ready;
  assign fifo_push     = capture_ok & (~fifo_full | fifo_pop);
  assign in_word.left  = i_input_sample_left;
  assign in_word.right = i_input_sample_right;
  assign cur_armed     = cur_buf ? b_armed : a_armed;
  assign cur_base      = cur_buf ? b_addr  : a_addr;
  assign cur_size      = cur_buf ? b_size  : a_size;
  assign last_word     = (index == cur_size - 32'd1);

  audio_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    read_data = '0;
    case (i_address)
      REG_CTRL: begin
        read_data[STAT_A_ARMED] = a_armed;
        read_data[STAT_B_ARMED] = b_armed;
        read_data[STAT_CUR_BUF] = cur_buf;
        read_data[STAT_OVERRUN] = overrun;
      end
      REG_BUF_A_ADDR: read_data = a_addr;
      REG_BUF_A_SIZE: read_data = a_size;
      REG_BUF_B_ADDR: read_data = b_addr;
      REG_BUF_B_SIZE: read_data = b_size;
      default:        read_data = '0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_meta <= i_input_sample_clock;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= DMA_IDLE;
      enable        <= 1'b0;
      overrun       <= 1'b0;
      cur_buf       <= 1'b0;
      a_armed       <= 1'b0;
      b_armed       <= 1'b0;
      stream_live   <= 1'b0;
      a_addr        <= '0;
      a_size        <= '0;
      b_addr        <= '0;
      b_size        <= '0;
      index         <= '0;
      o_rdata       <= '0;
      o_ready       <= 1'b0;
      o_dma_request <= 1'b0;
      o_dma_address <= '0;
      o_dma_wdata   <= '0;
      o_buffer_done <= 1'b0;
    end else begin
      o_ready       <= i_request;
      o_rdata       <= (i_request && !i_rw) ? read_data : '0;
      o_buffer_done <= 1'b0;

      case (state)
        DMA_IDLE: begin
          if (!fifo_empty && cur_armed) begin
            state         <= DMA_REQ;
            o_dma_request <= 1'b1;
            o_dma_address <= word_address(cur_base, index);
            o_dma_wdata   <= head_word;
          end
        end
        DMA_REQ: begin
          if (i_dma_ready) begin
            state         <= DMA_IDLE;
            o_dma_request <= 1'b0;
            if (last_word) begin
              index         <= '0;
              cur_buf       <= ~cur_buf;
              stream_live   <= 1'b1;
              o_buffer_done <= 1'b1;
              if (cur_buf) b_armed <= 1'b0;
              else         a_armed <= 1'b0;
            end else begin
              index <= index + 32'd1;
            end
          end
        end
        default: state <= DMA_IDLE;
      endcase

      // CPU writes land after the FSM so a same-cycle re-arm wins over a completion disarm
      if (i_request && i_rw) begin
        case (i_address)
          REG_CTRL: begin
            enable <= i_wdata[CTRL_ENABLE];
            if (!i_wdata[CTRL_ENABLE])     stream_live <= 1'b0;
            if (i_wdata[CTRL_CLR_OVERRUN]) overrun     <= 1'b0;
          end
          REG_BUF_A_ADDR: a_addr <= i_wdata;
          REG_BUF_A_SIZE: begin
            a_size  <= i_wdata;
            a_armed <= (i_wdata != '0);
          end
          REG_BUF_B_ADDR: b_addr <= i_wdata;
          REG_BUF_B_SIZE: begin
            b_size  <= i_wdata;
            b_armed <= (i_wdata != '0);
          end
          default: ;
        endcase
      end

      if (capture_ok && fifo_full && !fifo_pop) overrun <= 1'b1;
    end
  end

endmodule
